ram_read_streamer: RTL and testbench

- Sequential reader for the Hack-style register memory (RAM8 built from 16-bit load-enabled registers, expandable via parameter).
- On `start`, walks `count` consecutive addresses from `base_addr` and presents each stored word on a valid/ready output stream.
- It is the read-side counterpart of the register write path: it never drives `load`; it only drives the address and samples the memory's combinational output `Q`.
- It sits between the memory array and any consumer (screen/serial dump, checksum unit) that needs a block transfer.

---
 rtl/ram_read_streamer.sv | 106 ++++++++++
 tb/tb_ram_read_streamer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_streamer.sv
// Sequential block reader for a Hack-style register RAM: walks `count` words
// from `base_addr` and presents each one on a valid/ready output stream.
module ram_read_streamer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_q,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE  = 1;
  localparam logic [ADDR_W:0]   REM_ZERO = '0;

  state_t            state;
  logic [ADDR_W:0]   remaining;

  // READ spends one cycle with the address settled so mem_q is captured cleanly;
  // SEND holds out_data and mem_addr frozen until the consumer takes the word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != REM_ZERO) begin
              mem_addr  <= base_addr;
              remaining <= count;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end

        READ: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            state     <= IDLE;
          end else begin
            out_data  <= mem_q;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          // Abort wins over a same-cycle handshake: that word is not delivered.
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (remaining == REM_ONE) begin
              remaining <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              mem_addr  <= mem_addr + ADDR_ONE;
              remaining <= remaining - REM_ONE;
              state     <= READ;
            end
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Self-checking bench for ram_read_streamer: a behavioural RAM8 plus a
// queue-based model of the expected word stream and handshake timing.
module tb_ram_read_streamer;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BUDGET = 400;

  logic              CLK;
  logic              RST_N;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_q;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  logic [WIDTH-1:0]  mem [DEPTH];

  int assert_count = 0;
  int fail_count   = 0;

  ram_read_streamer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  assign mem_q = mem[mem_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One complete transfer: expected stream is just mem[(base+i) mod DEPTH].
  task automatic applyStimulus(input int base, input int cnt, input int stall_pct,
                               input int hold_low, input bit second_start, input bit with_abort);
    logic [ADDR_W-1:0] exp_addr [$];
    logic [WIDTH-1:0]  exp_data [$];
    logic [ADDR_W-1:0] a;
    int cycles;
    int low_left;
    bit hs;
    bit hold_valid;
    for (int i = 0; i < cnt; i++) begin
      a = ADDR_W'((base + i) % DEPTH);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
    @(negedge CLK);
    start     = 1'b1;
    abort     = with_abort;
    base_addr = ADDR_W'(base);
    count     = (ADDR_W+1)'(cnt);
    @(negedge CLK);
    start  = 1'b0;
    abort  = 1'b0;
    cycles = 1;
    if (cnt == 0) begin
      checkOutput("zero_done", {31'd0, done}, 32'd1);
      checkOutput("zero_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("zero_busy", {31'd0, busy}, 32'd0);
      @(negedge CLK);
      checkOutput("zero_done_single", {31'd0, done}, 32'd0);
      return;
    end
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    checkOutput("valid_after_start", {31'd0, out_valid}, 32'd0);
    low_left   = hold_low;
    hold_valid = 1'b0;
    while (exp_data.size() > 0 && cycles < BUDGET) begin
      if (hold_valid) checkOutput("valid_hold", {31'd0, out_valid}, 32'd1);
      checkOutput("busy_during", {31'd0, busy}, 32'd1);
      checkOutput("done_early", {31'd0, done}, 32'd0);
      if (out_valid) begin
        checkOutput("data", {16'd0, out_data}, {16'd0, exp_data[0]});
        checkOutput("addr", {29'd0, mem_addr}, {29'd0, exp_addr[0]});
      end
      if (out_valid && low_left > 0) begin
        out_ready = 1'b0;
        low_left--;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      if (second_start && cycles == 3) begin
        start     = 1'b1;
        base_addr = ADDR_W'(5);
        count     = (ADDR_W+1)'(2);
      end
      hs         = out_valid && out_ready;
      hold_valid = out_valid && !out_ready;
      @(negedge CLK);
      start = 1'b0;
      cycles++;
      if (hs) begin
        void'(exp_data.pop_front());
        void'(exp_addr.pop_front());
      end
    end
    if (exp_data.size() != 0) begin
      checkOutput("transfer_timeout", exp_data.size(), 32'd0);
      return;
    end
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("busy_fall", {31'd0, busy}, 32'd0);
    checkOutput("valid_end", {31'd0, out_valid}, 32'd0);
    if (stall_pct == 0 && hold_low == 0) checkOutput("latency", cycles, 2 * cnt + 1);
    @(negedge CLK);
    checkOutput("done_single", {31'd0, done}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, {29'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_data"}, {16'd0, out_data}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; count = '0;
    mem[0] = 16'hAAAA; mem[1] = 16'hBBBB; mem[2] = 16'hCCCC; mem[3] = 16'h0000;
    mem[4] = 16'hEEEE; mem[5] = 16'h1234; mem[6] = 16'h5678; mem[7] = 16'h9ABC;
    #3;
    checkAllZero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checkAllZero("post_reset");

    applyStimulus(0, 5, 0, 0, 1'b0, 1'b0);
    applyStimulus(6, 4, 0, 0, 1'b0, 1'b0);
    applyStimulus(1, 4, 0, 5, 1'b0, 1'b0);
    applyStimulus(2, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 3, 0, 0, 1'b1, 1'b0);

    // Abort while idle must do nothing; start together with abort is honoured.
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checkOutput("idle_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_abort_done", {31'd0, done}, 32'd0);
    applyStimulus(4, 2, 0, 0, 1'b0, 1'b1);

    // Abort in SEND of the second word, with a simultaneous handshake.
    out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b1; base_addr = '0; count = (ADDR_W+1)'(5);
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("abort_pre_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("abort_pre_data", {16'd0, out_data}, 32'h0000BBBB);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    @(negedge CLK);
    checkOutput("abort_done_late", {31'd0, done}, 32'd0);
    applyStimulus(3, 1, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges in the middle of a transfer.
    @(negedge CLK);
    start = 1'b1; base_addr = ADDR_W'(2); count = (ADDR_W+1)'(5);
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checkAllZero("after_async_reset");
    applyStimulus(2, 5, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'($urandom);
      applyStimulus($urandom_range(DEPTH - 1), $urandom_range(2 * DEPTH - 1),
                    $urandom_range(60), $urandom_range(3), 1'($urandom_range(1)),
                    1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
